// File: rtl/multicycle_control.sv
// multicycle_control: MIPS multi-cycle main control FSM (fetch/decode/exec/mem/wb), mem_ready handshake, retired-instruction counter
module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_operation,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
                         MEM_WB = 4'd4, MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7,
                         BRANCH = 4'd8, I_EXEC = 4'd9, I_WB = 4'd10, JUMP = 4'd11;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_LW = 6'h23, OP_SW = 6'h2b;
  logic [3:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [COUNT_W-1:0] instr_count_q, instr_count_d;
  logic pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c, illegal_c, retire;
  always_comb begin
    state_d = FETCH;
    op_d = op_q;
    pc_write_c = 1'b0;
    ir_write_c = 1'b0;
    i_or_d = 1'b0;
    mem_read_c = 1'b0;
    mem_write_c = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_operation = 3'b000;
    pc_source = 2'b00;
    illegal_c = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b = 2'b01;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_R: state_d = R_EXEC;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = I_EXEC;
          OP_J: state_d = JUMP;
          default: illegal_c = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d = op_q == OP_SW ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d = 1'b1;
        state_d = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write_c = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write_c = 1'b1;
        i_or_d = 1'b1;
        state_d = mem_ready ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_operation = 3'b010;
        state_d = R_WB;
      end
      R_WB: begin
        reg_write_c = 1'b1;
        reg_dst = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_operation = 3'b001;
        pc_source = 2'b01;
        pc_write_c = op_q == OP_BEQ ? zero : ~zero;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_operation = op_q == OP_ADDI ? 3'b100 : op_q == OP_ANDI ? 3'b101 : 3'b111;
        state_d = I_WB;
      end
      I_WB: reg_write_c = 1'b1;
      JUMP: begin
        pc_write_c = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
    retire = state_d == FETCH && state_q inside {MEM_WB, MEM_WRITE, R_WB, BRANCH, I_WB, JUMP};
    instr_count_d = instr_count_q + COUNT_W'(retire);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      op_q <= '0;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      instr_count_q <= instr_count_d;
    end
  end
  assign pc_write = pc_write_c & ~reset;
  assign ir_write = ir_write_c & ~reset;
  assign mem_read = mem_read_c & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign illegal_op = illegal_c & ~reset;
  assign state = state_q;
  assign instr_count = instr_count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level trace model checked against multicycle_control every cycle
module tb_multicycle_control;
  localparam logic [5:0] RT = 6'h00, J = 6'h02, BEQ = 6'h04, BNE = 6'h05, ADDI = 6'h08,
                         ANDI = 6'h0c, ORI = 6'h0d, LW = 6'h23, SW = 6'h2b;
  localparam logic [16:0] PCW = 17'd1 << 16, IRW = 17'd1 << 15, IORD = 17'd1 << 14, MR = 17'd1 << 13,
                          MW = 17'd1 << 12, M2R = 17'd1 << 11, RDST = 17'd1 << 10, RW = 17'd1 << 9,
                          ASA = 17'd1 << 8, ASB01 = 17'd1 << 6, ASB10 = 17'd2 << 6, ASB11 = 17'd3 << 6,
                          PS01 = 17'd1 << 1, PS10 = 17'd2 << 1, ILL = 17'd1;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_operation;
  logic [3:0] state;
  logic [31:0] instr_count;
  logic [16:0] outs;
  logic chk = 1'b0;
  logic [3:0] exp_state = '0;
  logic [16:0] exp_outs = '0;
  logic [31:0] exp_count = '0;
  logic [31:0] tr_sig = '0;
  int tr_n = 0;
  int checks = 0, errors = 0;
  multicycle_control #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_operation(alu_operation),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  assign outs = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                 alu_src_a, alu_src_b, alu_operation, pc_source, illegal_op};
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) if (chk) begin
    tr_sig = {tr_sig[27:0], state};
    tr_n++;
    check("state", 32'(state), 32'(exp_state));
    check("outs", 32'(outs), 32'(exp_outs));
    check("count", instr_count, exp_count);
  end
  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction
  function automatic logic [16:0] aop(input logic [2:0] a);
    return 17'(a) << 3;
  endfunction
  task automatic cyc(input logic [3:0] st, input logic [5:0] op, input logic mr, input logic z, input logic [16:0] o);
    opcode = op;
    mem_ready = mr;
    zero = z;
    exp_state = st;
    exp_outs = o;
    chk = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [5:0] op, input int fw, input int mw, input logic z);
    logic [5:0] x;
    x = ~op;
    repeat (fw) cyc(4'd0, x, 1'b0, rb(), MR | ASB01);
    cyc(4'd0, x, 1'b1, rb(), PCW | IRW | MR | ASB01);
    if (!(op inside {RT, J, BEQ, BNE, ADDI, ANDI, ORI, LW, SW})) begin
      cyc(4'd1, op, rb(), rb(), ASB11 | ILL);
      return;
    end
    cyc(4'd1, op, rb(), rb(), ASB11);
    if (op == LW || op == SW) cyc(4'd2, x, rb(), rb(), ASA | ASB10);
    if (op == LW) begin
      repeat (mw) cyc(4'd3, x, 1'b0, rb(), MR | IORD);
      cyc(4'd3, x, 1'b1, rb(), MR | IORD);
      cyc(4'd4, x, rb(), rb(), RW | M2R);
    end else if (op == SW) begin
      repeat (mw) cyc(4'd5, x, 1'b0, rb(), MW | IORD);
      cyc(4'd5, x, 1'b1, rb(), MW | IORD);
    end else if (op == RT) begin
      cyc(4'd6, x, rb(), rb(), ASA | aop(3'b010));
      cyc(4'd7, x, rb(), rb(), RW | RDST);
    end else if (op == BEQ || op == BNE) begin
      cyc(4'd8, x, rb(), z, ASA | aop(3'b001) | PS01 | (((op == BEQ) == z) ? PCW : 17'd0));
    end else if (op == J) begin
      cyc(4'd11, x, rb(), rb(), PCW | PS10);
    end else begin
      cyc(4'd9, x, rb(), rb(), ASA | ASB10 | aop(op == ADDI ? 3'b100 : op == ANDI ? 3'b101 : 3'b111));
      cyc(4'd10, x, rb(), rb(), RW);
    end
    exp_count = exp_count + 1;
  endtask
  initial begin
    int n0;
    mem_ready = 1'b1;
    exp_state = 4'd0;
    exp_outs = ASB01;
    chk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n0 = tr_n;
    run(RT, 0, 0, 1'b0);
    check("rt_cycles", 32'(tr_n - n0), 32'd4);
    check("rt_trace", {16'd0, tr_sig[15:0]}, 32'h0000_0167);
    check("rt_count", instr_count, 32'd1);
    n0 = tr_n;
    run(LW, 0, 2, 1'b0);
    check("lw_cycles", 32'(tr_n - n0), 32'd7);
    check("lw_trace", {4'd0, tr_sig[27:0]}, 32'h0123_334);
    run(BEQ, 0, 0, 1'b1);
    run(BNE, 0, 0, 1'b1);
    check("br_count", instr_count, 32'd4);
    run(ADDI, 1, 0, 1'b0);
    run(ANDI, 0, 0, 1'b0);
    run(ORI, 2, 0, 1'b0);
    run(BNE, 0, 0, 1'b0);
    run(BEQ, 0, 0, 1'b0);
    n0 = tr_n;
    run(6'h3f, 0, 0, 1'b0);
    check("ill_cycles", 32'(tr_n - n0), 32'd2);
    check("ill_trace", {24'd0, tr_sig[7:0]}, 32'h0000_0001);
    check("ill_next_state", 32'(state), 32'd0);
    check("ill_count", instr_count, 32'd9);
    run(SW, 1, 1, 1'b0);
    run(LW, 0, 0, 1'b0);
    cyc(4'd0, 6'h00, 1'b1, 1'b0, PCW | IRW | MR | ASB01);
    cyc(4'd1, SW, 1'b0, 1'b0, ASB11);
    cyc(4'd2, 6'h00, 1'b0, 1'b0, ASA | ASB10);
    cyc(4'd5, 6'h00, 1'b0, 1'b0, MW | IORD);
    mem_ready = 1'b0;
    reset = 1'b1;
    exp_state = 4'd0;
    exp_outs = ASB01;
    exp_count = '0;
    #1;
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", instr_count, 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(J, 0, 0, 1'b0);
    check("post_rst_count", instr_count, 32'd1);
    force dut.instr_count_q = '1;
    #1;
    release dut.instr_count_q;
    exp_count = '1;
    run(J, 0, 0, 1'b0);
    check("wrap_count", instr_count, 32'd0);
    run(RT, 0, 0, 1'b0);
    check("after_wrap_count", instr_count, 32'd1);
    chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control FSM for the MIPS processor. Sequences each instruction through fetch, decode, execute, memory and writeback states and drives the datapath select and strobe signals. It generates the 3-bit `alu_operation` code consumed by the ALU control decoder. Memory accesses use a `mem_ready` handshake, and the block counts retired instructions.

## Interface
Parameters:
- `COUNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  instruction[31:26] from the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `pc_write`  out  1  load PC.
- `ir_write`  out  1  load instruction register.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `mem_to_reg`  out  1  register write data select: 1 = MDR, 0 = ALUOut.
- `reg_dst`  out  1  destination register select: 1 = rd, 0 = rt.
- `reg_write`  out  1  register file write strobe.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B select: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_operation`  out  3  code sent to the ALU control decoder.
- `pc_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `illegal_op`  out  1  one-cycle pulse when an unknown opcode is decoded.
- `state`  out  4  current state, for debug.
- `instr_count`  out  `COUNT_W`  number of retired instructions.

## Operation
- State register: 4 bits. Encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, I_EXEC=9, I_WB=10, JUMP=11
  - Codes 12-15 are unreachable and transition to FETCH.
- Outputs are a combinational decode of the state, of `op_q` (the opcode latched in DECODE), and of `mem_ready`/`zero` where listed below.
- Default for every output is 0. `alu_operation` defaults to 000 (add).
- FETCH:
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `pc_source`=00.
  - When `mem_ready` is high: `ir_write`=1, `pc_write`=1, next state DECODE. Otherwise the FSM stays in FETCH.
- DECODE:
  - Drives `alu_src_b`=11, `alu_operation`=000, and latches `opcode` into `op_q`.
  - Next state by opcode:
    - lw (100011) or sw (101011) -> MEM_ADDR
    - R-type (000000) -> R_EXEC
    - beq (000100) or bne (000101) -> BRANCH
    - addi (001000), andi (001100) or ori (001101) -> I_EXEC
    - j (000010) -> JUMP
    - any other opcode -> FETCH with `illegal_op`=1 for that cycle; no counter increment.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_operation`=000. Next state MEM_READ if `op_q` is lw, MEM_WRITE if sw.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Stays until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next state FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. Stays until `mem_ready`, then FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_operation`=010. Next state R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1. Next state FETCH.
- BRANCH:
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_operation`=001, `pc_source`=01.
  - `pc_write` = `zero` for beq, ~`zero` for bne.
  - Next state FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10. `alu_operation` = 100 for addi, 101 for andi, 111 for ori. Next state I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next state FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Next state FETCH.
- `instr_count`:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH (taken or not), I_WB or JUMP.
  - Wraps modulo 2^`COUNT_W`.
- Reset:
  - State is forced to FETCH, `op_q` to 0, `instr_count` to 0.
  - While `reset` is high, `mem_read`, `mem_write`, `pc_write`, `ir_write`, `reg_write` and `illegal_op` are forced to 0.
  - All other outputs take their FETCH values: `alu_src_b`=01, rest 0.
  - Reset asserted mid-instruction aborts it immediately; no partial writeback strobe occurs after reset asserts.

## Timing
- Cycles per instruction with `mem_ready` already high at each memory state: j 3, beq/bne 3, R-type 4, addi/andi/ori 4, sw 4, lw 5.
- Each low cycle of `mem_ready` in FETCH, MEM_READ or MEM_WRITE adds one cycle. The request stays asserted and the address select stays stable throughout the wait.
- `pc_write`/`ir_write` in FETCH and `pc_write` in BRANCH are combinational on `mem_ready`/`zero` in the same cycle.
- `illegal_op` is high for exactly one cycle (DECODE); the next cycle is FETCH.
- First FETCH begins on the first rising edge after `reset` deasserts.

## Test plan
- Reset with `mem_ready`=1, then opcode 000000: states 0,1,6,7,0. `alu_operation` = 000 in FETCH, 010 in R_EXEC. `reg_write`=1, `reg_dst`=1 only in R_WB. `instr_count`=1.
- lw with `mem_ready` low for 2 cycles in MEM_READ: states 0,1,2,3,3,3,4,0. `mem_read`=1 and `i_or_d`=1 held for 3 cycles; `mem_to_reg`=1 in MEM_WB.
- beq with `zero`=1, then bne with `zero`=1: first has `pc_write`=1, `pc_source`=01, `alu_operation`=001; second has `pc_write`=0. `instr_count` increments by 2.
- addi, andi, ori in sequence: I_EXEC `alu_operation` = 100, 101, 111 respectively; each followed by I_WB with `reg_write`=1, `reg_dst`=0.
- Opcode 111111: `illegal_op` pulses for 1 cycle in DECODE, then FETCH; `instr_count` unchanged.
- Assert `reset` during MEM_WRITE with `mem_ready` low: `mem_write` drops to 0 asynchronously; state=0 and `instr_count`=0 after release.
- Preload `instr_count` to all-ones via a hierarchical force, then execute j: `instr_count` wraps to 0.
